// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg: shared FSM encoding and helpers for the receive word packer.
`default_nettype none

package udp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  function automatic int max_len(input int aw);
    return 1 << aw;
  endfunction

  // Output lane that the cnt-th byte of a word lands in.
  function automatic int lane_idx(input int cnt, input int nbytes, input bit big_endian);
    return big_endian ? (nbytes - 1 - cnt) : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udp_rx_word_packer_fifo.sv
// sync_fifo_fwft: single-clock show-ahead FIFO with level and registered almost_full.
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 64,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       almost_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int AF = DEPTH - AFULL_MARGIN;
  localparam logic [LW-1:0] FULL_LVL  = DEPTH[LW-1:0];
  localparam logic [LW-1:0] AFULL_LVL = AF[LW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             afull_q;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en_i && (level_q != FULL_LVL);
  assign w_pop  = rd_en_i && (level_q != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(w_push) - LW'(w_pop);
      // Deliberately built from the old level; the margin covers the lag.
      afull_q <= (level_q >= AFULL_LVL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign valid_o       = (level_q != '0);
  assign rd_data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o       = level_q;
  assign almost_full_o = afull_q;

endmodule

`default_nettype wire

// File: rtl/udp_rx_word_packer.sv
// udp_rx_word_packer: drains one UDP payload from the byte-wide receive RAM
// and packs it into OUT_BYTES-wide words behind a valid/ready FIFO.
`default_nettype none

module udp_rx_word_packer
  import udp_rx_pkg::*;
#(
  parameter int RAM_AW       = 11,
  parameter int RAM_LAT      = 1,
  parameter int OUT_BYTES    = 2,
  parameter int BIG_ENDIAN   = 1,
  parameter int FIFO_DEPTH   = 64,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         rx_pkt_valid,
  input  logic [15:0]                  rx_pkt_len,
  output logic                         rx_pkt_ack,
  output logic                         len_err,
  output logic                         ram_rd_en,
  output logic [RAM_AW-1:0]            ram_rd_addr,
  input  logic [7:0]                   ram_rdata,
  output logic [8*OUT_BYTES-1:0]       m_data,
  output logic [OUT_BYTES-1:0]         m_keep,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         almost_full
);

  localparam int W   = 8 * OUT_BYTES;
  localparam int CW  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int FW  = W + OUT_BYTES + 1;
  localparam int MAX_LEN = max_len(RAM_AW);
  localparam logic [16:0] MAX_LEN_W = MAX_LEN[16:0];

  state_e              state_q, state_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [16:0]         rem_q, rem_d;
  logic                err_q, err_d;
  logic                done_q;
  logic [RAM_LAT-1:0]  vld_sr_q, lst_sr_q;
  logic [CW-1:0]       lane_q;
  logic [W-1:0]        acc_data_q;
  logic [OUT_BYTES-1:0] acc_keep_q;
  logic                wr_q, wr_last_q;
  logic [W-1:0]        wr_data_q;
  logic [OUT_BYTES-1:0] wr_keep_q;

  logic                w_rd_en, w_rd_last, w_len_ok, w_afull;
  logic                w_cap, w_cap_last, w_word_done;
  logic [W-1:0]        w_word;
  logic [OUT_BYTES-1:0] w_keep;
  int                  w_lane;
  logic [FW-1:0]       w_fifo_out;

  assign w_len_ok = (rx_pkt_len != 16'd0) && ({1'b0, rx_pkt_len} <= MAX_LEN_W);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    err_d     = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_pkt_valid) begin
          if (w_len_ok) begin
            rem_d   = {1'b0, rx_pkt_len};
            addr_d  = '0;
            state_d = ST_READ;
          end else begin
            // Rejected packets pass through DRAIN so the ack trails len_err by one cycle.
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_READ: begin
        if (!w_afull) begin
          w_rd_en = 1'b1;
          addr_d  = addr_q + RAM_AW'(1);
          rem_d   = rem_q - 17'd1;
          if (rem_q == 17'd1) begin
            w_rd_last = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (err_q || (done_q && (vld_sr_q == '0))) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cap       = vld_sr_q[RAM_LAT-1];
    w_cap_last  = lst_sr_q[RAM_LAT-1];
    w_lane      = lane_idx(int'(lane_q), OUT_BYTES, BIG_ENDIAN != 0);
    w_word      = acc_data_q | (W'(ram_rdata) << (8 * w_lane));
    w_keep      = acc_keep_q | (OUT_BYTES'(1) << w_lane);
    w_word_done = (lane_q == CW'(OUT_BYTES - 1)) || w_cap_last;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      vld_sr_q   <= '0;
      lst_sr_q   <= '0;
      lane_q     <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      wr_q       <= 1'b0;
      wr_data_q  <= '0;
      wr_keep_q  <= '0;
      wr_last_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      vld_sr_q <= (vld_sr_q << 1) | RAM_LAT'(w_rd_en);
      lst_sr_q <= (lst_sr_q << 1) | RAM_LAT'(w_rd_last);
      wr_q     <= 1'b0;
      if (state_q == ST_ACK) done_q <= 1'b0;
      else if (w_cap && w_cap_last) done_q <= 1'b1;
      if (w_cap) begin
        if (w_word_done) begin
          wr_q       <= 1'b1;
          wr_data_q  <= w_word;
          wr_keep_q  <= w_keep;
          wr_last_q  <= w_cap_last;
          acc_data_q <= '0;
          acc_keep_q <= '0;
          lane_q     <= '0;
        end else begin
          acc_data_q <= w_word;
          acc_keep_q <= w_keep;
          lane_q     <= lane_q + CW'(1);
        end
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH       (FW),
    .DEPTH       (FIFO_DEPTH),
    .AFULL_MARGIN(AFULL_MARGIN)
  ) u_fifo (
    .clk_i        (sys_clk),
    .rst_n_i      (rst_n),
    .wr_en_i      (wr_q),
    .wr_data_i    ({wr_last_q, wr_keep_q, wr_data_q}),
    .rd_en_i      (m_ready),
    .rd_data_o    (w_fifo_out),
    .valid_o      (m_valid),
    .level_o      (fifo_level),
    .almost_full_o(w_afull)
  );

  assign m_data      = w_fifo_out[W-1:0];
  assign m_keep      = w_fifo_out[W +: OUT_BYTES];
  assign m_last      = w_fifo_out[FW-1];
  assign almost_full = w_afull;
  assign ram_rd_en   = w_rd_en;
  assign ram_rd_addr = addr_q;
  assign len_err     = err_q;
  assign rx_pkt_ack  = (state_q == ST_ACK);

endmodule

`default_nettype wire

// File: tb/tb_udp_rx_word_packer.sv
// tb_udp_rx_word_packer: randomized scoreboard bench for udp_rx_word_packer.
`timescale 1ns/1ps
`default_nettype none

module tb_udp_rx_word_packer;

  localparam int RAM_AW  = 8;
  localparam int RAM_LAT = 2;
  localparam int OB      = 4;
  localparam int BE      = 1;
  localparam int DEPTH   = 8;
  localparam int MARGIN  = 4;
  localparam int MAXL    = 1 << RAM_AW;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_pkt_valid = 1'b0;
  logic [15:0]       rx_pkt_len = '0;
  logic              rx_pkt_ack, len_err, ram_rd_en;
  logic [RAM_AW-1:0] ram_rd_addr;
  logic [7:0]        ram_rdata;
  logic [8*OB-1:0]   m_data;
  logic [OB-1:0]     m_keep;
  logic              m_last, m_valid;
  logic              m_ready = 1'b0;
  logic [LW-1:0]     fifo_level;
  logic              almost_full;

  always #5 sys_clk = ~sys_clk;

  udp_rx_word_packer #(
    .RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .OUT_BYTES(OB), .BIG_ENDIAN(BE),
    .FIFO_DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_pkt_valid(rx_pkt_valid), .rx_pkt_len(rx_pkt_len),
    .rx_pkt_ack(rx_pkt_ack), .len_err(len_err), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rdata(ram_rdata), .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_level(fifo_level), .almost_full(almost_full)
  );

  // Receive RAM with RAM_LAT read latency; idle cycles return noise.
  logic [7:0] mem  [MAXL];
  logic [7:0] pipe [RAM_LAT];
  always @(posedge sys_clk) begin
    pipe[0] <= ram_rd_en ? mem[ram_rd_addr] : 8'($urandom);
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RAM_LAT-1];

  typedef struct packed {
    logic [8*OB-1:0] d;
    logic [OB-1:0]   k;
    logic            l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   hold = 1'b1;
  bit   rnd_ready = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge sys_clk);
    #2;
    m_ready = hold ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  always @(negedge sys_clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {32'd0, m_data}, 64'hDEAD);
      end else begin
        mon_e = sb.pop_front();
        chk("m_data", 64'(m_data), 64'(mon_e.d));
        chk("m_keep", 64'(m_keep), 64'(mon_e.k));
        chk("m_last", 64'(m_last), 64'(mon_e.l));
      end
    end
  end

  // Reference: payload split into OB-byte groups; lane order from BE.
  task automatic load_pkt(input int len, input bit seq, input bit expect_words);
    exp_t e;
    int   lane;
    for (int i = 0; i < len; i++) mem[i] = seq ? 8'(i + 1) : 8'($urandom);
    if (expect_words) begin
      for (int w = 0; w * OB < len; w++) begin
        e = '0;
        for (int b = 0; b < OB && (w * OB + b) < len; b++) begin
          lane = BE ? (OB - 1 - b) : b;
          e.d[8*lane +: 8] = mem[w * OB + b];
          e.k[lane] = 1'b1;
        end
        e.l = ((w + 1) * OB >= len);
        sb.push_back(e);
      end
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ack"},    64'(rx_pkt_ack), 0);
    chk({pfx, "_lenerr"}, 64'(len_err), 0);
    chk({pfx, "_rd_en"},  64'(ram_rd_en), 0);
    chk({pfx, "_addr"},   64'(ram_rd_addr), 0);
    chk({pfx, "_mdata"},  64'(m_data), 0);
    chk({pfx, "_mkeep"},  64'(m_keep), 0);
    chk({pfx, "_mlast"},  64'(m_last), 0);
    chk({pfx, "_mvalid"}, 64'(m_valid), 0);
    chk({pfx, "_level"},  64'(fifo_level), 0);
    chk({pfx, "_afull"},  64'(almost_full), 0);
  endtask

  task automatic run_pkt(input int len, input bit seq, input int hold_cyc, input bit rnd);
    bit err;
    bit clean;
    bit saw_af;
    int start, nrd, nerr, first, last, err_cyc, ack_cyc, addr_bad, maxlvl, k;
    err = (len == 0) || (len > MAXL);
    load_pkt(err ? 0 : len, seq, !err);
    @(posedge sys_clk);
    #1;
    rnd_ready    = rnd;
    hold         = (hold_cyc > 0);
    start        = cyc;
    clean        = (fifo_level == 0) && !almost_full;
    rx_pkt_valid = 1'b1;
    rx_pkt_len   = 16'(len);
    nrd = 0; nerr = 0; first = -1; last = -1; err_cyc = -1; ack_cyc = -1;
    addr_bad = 0; maxlvl = 0; k = 0; saw_af = 1'b0;
    while (ack_cyc < 0 && k < 6000) begin
      @(negedge sys_clk);
      k++;
      if (k == hold_cyc) hold = 1'b0;
      if (ram_rd_en) begin
        if (ram_rd_addr !== RAM_AW'(nrd)) addr_bad++;
        if (first < 0) first = cyc;
        last = cyc;
        nrd++;
      end
      if (almost_full) saw_af = 1'b1;
      if (len_err) begin nerr++; err_cyc = cyc; end
      if (rx_pkt_ack) ack_cyc = cyc;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    hold = 1'b0;
    chk("ack_seen", 64'(ack_cyc >= 0), 1);
    @(posedge sys_clk);
    #1;
    rx_pkt_valid = 1'b0;
    if (err) begin
      chk("len_err_count", 64'(nerr), 1);
      chk("len_err_cycle", 64'(err_cyc), 64'(start + 1));
      chk("err_ack_cycle", 64'(ack_cyc), 64'(start + 2));
      chk("err_reads", 64'(nrd), 0);
    end else begin
      chk("no_len_err", 64'(nerr), 0);
      chk("read_count", 64'(nrd), 64'(len));
      chk("read_addr_seq", 64'(addr_bad), 0);
      chk("ack_latency", 64'(ack_cyc - last), 64'(RAM_LAT + 2));
      chk("addr_after_pkt", 64'(ram_rd_addr), 64'(len % MAXL));
      if (clean) chk("first_read_latency", 64'(first), 64'(start + 1));
      if (!saw_af) chk("read_phase_len", 64'(last - first), 64'(len - 1));
      if (hold_cyc > 0) chk("stall_seen", 64'(saw_af), 1);
    end
    chk("level_bound", 64'(maxlvl <= DEPTH), 1);
  endtask

  task automatic drain();
    int k;
    hold = 1'b0;
    rnd_ready = 1'b0;
    k = 0;
    while ((sb.size() != 0 || m_valid) && k < 1000) begin
      @(negedge sys_clk);
      k++;
    end
    chk("scoreboard_empty", 64'(sb.size()), 0);
    chk("fifo_empty", 64'(m_valid), 0);
  endtask

  task automatic reset_mid();
    int nack, nrd;
    load_pkt(100, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    hold = 1'b1;
    rx_pkt_valid = 1'b1;
    rx_pkt_len = 16'd100;
    repeat (12) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    rx_pkt_valid = 1'b0;
    @(negedge sys_clk);
    chk_reset_vals("mid_reset");
    nack = 0; nrd = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (rx_pkt_ack) nack++;
      if (ram_rd_en) nrd++;
    end
    chk("no_ack_after_reset", 64'(nack), 0);
    chk("no_reads_after_reset", 64'(nrd), 0);
    hold = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_reset_vals("reset");
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    hold = 1'b0;

    run_pkt(0, 1'b0, 0, 1'b0);
    run_pkt(MAXL + 1, 1'b0, 0, 1'b0);
    repeat (3) @(negedge sys_clk);
    chk("err_fifo_valid", 64'(m_valid), 0);
    chk("err_fifo_level", 64'(fifo_level), 0);

    run_pkt(5, 1'b1, 0, 1'b0);
    run_pkt(6, 1'b1, 0, 1'b0);
    run_pkt(7, 1'b0, 0, 1'b0);
    run_pkt(8, 1'b0, 0, 1'b0);
    run_pkt(1, 1'b0, 0, 1'b0);
    run_pkt(3, 1'b0, 0, 1'b0);
    drain();

    run_pkt(64, 1'b0, 60, 1'b0);
    drain();

    run_pkt(MAXL, 1'b0, 0, 1'b1);
    drain();

    reset_mid();
    run_pkt(9, 1'b1, 0, 1'b0);
    drain();

    repeat (6) run_pkt(int'($urandom_range(1, MAXL)), 1'b0, 0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
